delay_timer_mc: RTL and testbench

- Multi-channel programmable delay timer; successor to the single-channel fixed-N delay counter.
- NCH independent channels, each with a runtime-programmable limit and a periodic/one-shot mode.
- Each channel emits a one-cycle `sig` pulse every limit+1 counted cycles, plus `flg`/`err` status.
- Sits between the control register block and downstream timeout/handshake logic that consumes the `sig` pulses.

---
 rtl/delay_timer_mc.sv | 115 +++++++++++
 tb/tb_delay_timer_mc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay timer: per-channel IDLE/RUN/DONE FSM emitting a one-cycle sig every limit+1 counts.
// Optional shared prescaler enabled by `define DELAY_TIMER_PRESCALE_EN (counters advance once every PRESC cycles).
module delay_timer_mc #(
  parameter int NCH       = 4,
  parameter int CBITS     = 19,
  parameter int DEF_LIMIT = 400000,
`ifdef DELAY_TIMER_PRESCALE_EN
  parameter int PRESC     = 10,
`endif
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_limit,
  input  logic             cfg_mode,
  input  logic [NCH-1:0]   err_clr,
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           st   [NCH];
  logic [CBITS-1:0] cnt  [NCH];
  logic [CBITS-1:0] lim  [NCH];
  logic [NCH-1:0]   mode;
  logic [NCH-1:0]   hit;
  logic             tick;

`ifdef DELAY_TIMER_PRESCALE_EN
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  logic [PW-1:0] presc_cnt;

  assign tick = (presc_cnt == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_cnt <= '0;
    else      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  // Out-of-range cfg_ch never matches any channel index, so such writes fall through silently.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++)
      hit[i] = cfg_we && (cfg_ch == CHW'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
        lim[i] <= CBITS'(DEF_LIMIT);
      end
      mode <= '0;
      sig  <= '0;
      flg  <= '0;
      err  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sig[i] <= 1'b0;
        // A new violation outranks a simultaneous clear.
        err[i] <= (err[i] & ~err_clr[i]) | (hit[i] && st[i] == RUN);
        if (hit[i] && st[i] != RUN) begin
          lim[i]  <= cfg_limit;
          mode[i] <= cfg_mode;
        end
        case (st[i])
          IDLE: begin
            cnt[i] <= '0;
            if (en[i]) begin
              st[i]  <= RUN;
              flg[i] <= 1'b1;
            end
          end
          RUN: begin
            if (!en[i]) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
              flg[i] <= 1'b0;
            end else if (tick) begin
              if (cnt[i] == lim[i]) begin
                cnt[i] <= '0;
                sig[i] <= 1'b1;
                if (mode[i]) begin
                  st[i]  <= DONE;
                  flg[i] <= 1'b0;
                end
              end else begin
                cnt[i] <= cnt[i] + CBITS'(1);
              end
            end
          end
          DONE: begin
            cnt[i] <= '0;
            if (!en[i]) st[i] <= IDLE;
          end
          default: begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
            flg[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_timer_mc.sv
// Directed bench for delay_timer_mc: a 4-channel and a 3-channel instance sharing the config bus.
module tb_delay_timer_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en_a, err_clr_a, sig_a, flg_a, err_a;
  logic [2:0] en_b, err_clr_b, sig_b, flg_b, err_b;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_limit;
  logic       cfg_mode;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n;
  logic [1:0] exp2;

  always #5 clk = ~clk;

  delay_timer_mc #(
    .NCH(4), .CBITS(8), .DEF_LIMIT(5)
`ifdef DELAY_TIMER_PRESCALE_EN
    , .PRESC(4)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_limit(cfg_limit), .cfg_mode(cfg_mode), .err_clr(err_clr_a),
    .sig(sig_a), .flg(flg_a), .err(err_a)
  );

  delay_timer_mc #(
    .NCH(3), .CBITS(8), .DEF_LIMIT(5)
`ifdef DELAY_TIMER_PRESCALE_EN
    , .PRESC(1)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_limit(cfg_limit), .cfg_mode(cfg_mode), .err_clr(err_clr_b),
    .sig(sig_b), .flg(flg_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts falling edges until the chosen sig bit is seen high; -1 if the budget runs out.
  task automatic wait_pulse(input bit use_b, input int ch, input int maxc, output int cnt);
    bit done;
    cnt  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cnt++;
      if (use_b ? sig_b[ch] : sig_a[ch]) done = 1'b1;
      else if (cnt >= maxc) begin
        cnt  = -1;
        done = 1'b1;
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] lim, input logic md);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_limit = lim;
    cfg_mode  = md;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en_a = '0; en_b = '0; err_clr_a = '0; err_clr_b = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0; cfg_mode = 1'b0;
    #1;
    check("reset_a", {sig_a, flg_a, err_a}, 0);
    check("reset_b", {sig_b, flg_b, err_b}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

`ifdef DELAY_TIMER_PRESCALE_EN
    cfg_write(2'd0, 8'd2, 1'b0);
    en_a[0] = 1'b1;
    wait_pulse(1'b0, 0, 60, n);
    check("presc_first_seen", n > 0, 1);
    wait_pulse(1'b0, 0, 60, n);
    check("presc_period1", n, 12);
    wait_pulse(1'b0, 0, 60, n);
    check("presc_period2", n, 12);
`else
    // Default limit 5: first pulse after 7 falling edges, then every 6.
    en_a[0] = 1'b1;
    wait_pulse(1'b0, 0, 20, n);
    check("t1_first", n, 7);
    wait_pulse(1'b0, 0, 20, n);
    check("t1_period1", n, 6);
    wait_pulse(1'b0, 0, 20, n);
    check("t1_period2", n, 6);

    // Write to running ch0 is rejected and flags err.
    cfg_write(2'd0, 8'd9, 1'b0);
    check("t3_err_set", err_a, 4'b0001);
    wait_pulse(1'b0, 0, 20, n);
    check("t3_limit_kept", n, 5);
    wait_pulse(1'b0, 0, 20, n);
    check("t3_period", n, 6);
    err_clr_a[0] = 1'b1;
    cfg_write(2'd0, 8'd9, 1'b0);
    err_clr_a[0] = 1'b0;
    check("t3_set_wins", err_a[0], 1);
    err_clr_a[0] = 1'b1;
    @(negedge clk);
    err_clr_a[0] = 1'b0;
    check("t3_cleared", err_a[0], 0);
    en_a[0] = 1'b0;
    @(negedge clk);
    check("t3_idle_flg", flg_a[0], 0);

    // ch1 one-shot limit 3, ch2 periodic limit 0.
    cfg_write(2'd1, 8'd3, 1'b1);
    cfg_write(2'd2, 8'd0, 1'b0);
    check("t2_no_err", err_a, 0);
    en_a[2:1] = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp2 = {k >= 2, k == 5};
      check("t2_sig", sig_a[2:1], exp2);
      check("t2_flg1", flg_a[1], k < 5);
    end
    wait_pulse(1'b0, 1, 15, n);
    check("t2_oneshot_hold", n, -1);
    en_a[2:1] = 2'b00;
    @(negedge clk);

    // Async reset mid-count drops everything and reverts ch1 to default limit/periodic.
    en_a[0] = 1'b1;
    @(negedge clk);
    cfg_write(2'd0, 8'd7, 1'b0);
    check("rst_pre_state", {flg_a[0], err_a[0]}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("rst_async", {sig_a, flg_a, err_a}, 0);
    en_a = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    en_a[1] = 1'b1;
    wait_pulse(1'b0, 1, 20, n);
    check("rst_limit_lost", n, 7);
    wait_pulse(1'b0, 1, 20, n);
    check("rst_mode_lost", n, 6);
    en_a[1] = 1'b0;
    @(negedge clk);

    // ch3 limit 2: en drops on the terminal-count edge.
    cfg_write(2'd3, 8'd2, 1'b0);
    en_a[3] = 1'b1;
    repeat (3) @(negedge clk);
    en_a[3] = 1'b0;
    @(negedge clk);
    check("t4_no_sig", sig_a[3], 0);
    check("t4_idle", flg_a[3], 0);
    @(negedge clk);
    check("t4_still_quiet", sig_a[3], 0);
    en_a[3] = 1'b1;
    wait_pulse(1'b0, 3, 20, n);
    check("t4_rearm_first", n, 4);
    wait_pulse(1'b0, 3, 20, n);
    check("t4_rearm_period", n, 3);
    en_a[3] = 1'b0;

    // 3-channel instance: cfg_ch=3 is out of range.
    en_b[0] = 1'b1;
    @(negedge clk);
    cfg_write(2'd3, 8'd1, 1'b1);
    check("t5_no_err", err_b, 0);
    wait_pulse(1'b1, 0, 20, n);
    check("t5_ch0_untouched", n, 5);
    en_b[2] = 1'b1;
    wait_pulse(1'b1, 2, 20, n);
    check("t5_ch2_untouched", n, 7);
    wait_pulse(1'b1, 2, 20, n);
    check("t5_ch2_periodic", n, 6);
    check("t5_err_final", err_b, 0);
    en_b = '0;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
